// File: rtl/ppt_seq_pkg.sv
// ppt_seq_pkg: widths, FSM states and phase entry type
// shared by the phase sequencer and its phase table.
package ppt_seq_pkg;

  localparam int CNT_W  = 16;
  localparam int OUT_W  = 4;
  localparam int NUM_PH = 4;
  localparam int PH_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] out;
  } phase_ent_t;

endpackage

// File: rtl/ppt_phase_table.sv
// ppt_phase_table: NUM_PH-entry phase register file,
// synchronous write, combinational read, async clear.
module ppt_phase_table
  import ppt_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [PH_W-1:0] waddr_i,
  input  phase_ent_t      wdata_i,
  input  logic [PH_W-1:0] raddr_i,
  output phase_ent_t      rdata_o
);

  phase_ent_t mem_q [NUM_PH];

  // One entry written per strobe; whole table clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ppt_phase_sequencer.sv
// ppt_phase_sequencer: steps the pulse counter through the phase table.
// Optional per-phase watchdog enabled by `define PPT_SEQ_TIMEOUT_EN.
module ppt_phase_sequencer
  import ppt_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PH_W-1:0]  cfg_addr,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [OUT_W-1:0] cfg_out,
  input  logic [PH_W-1:0]  last_ph,
  input  logic             loop_en,
  input  logic             start,
  input  logic             abort,
  output logic [CNT_W-1:0] cnt_load,
  output logic             cnt_run,
  input  logic             cnt_done,
  output logic [OUT_W-1:0] phase_out,
  output logic [PH_W-1:0]  phase_idx,
  output logic             busy,
  output logic             seq_done,
  output logic [7:0]       loop_cnt,
  output logic             timeout_err
);

  seq_state_e       state_q;
  logic [PH_W-1:0]  idx_q;
  logic [PH_W-1:0]  last_q;
  logic [PH_W-1:0]  nxt_idx_d;
  logic [CNT_W-1:0] cnt_load_q;
  logic [OUT_W-1:0] phase_out_q;
  logic             cnt_run_q;
  logic             busy_q;
  logic             seq_done_q;
  logic [7:0]       loop_q;
  phase_ent_t       wr_ent;
  phase_ent_t       rd_ent;

`ifdef PPT_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;
  logic            tmo_q;
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign wr_ent = '{count: cfg_count, out: cfg_out};

  ppt_phase_table u_table (
    .clk     (clk),
    .rst     (rst),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (wr_ent),
    .raddr_i (nxt_idx_d),
    .rdata_o (rd_ent)
  );

  always_comb begin
    nxt_idx_d = '0;
    if (state_q == S_RUN && idx_q != last_q) begin
      nxt_idx_d = idx_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      cnt_load_q  <= '0;
      phase_out_q <= '0;
      cnt_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      loop_q      <= '0;
`ifdef PPT_SEQ_TIMEOUT_EN
      wd_q        <= '0;
      tmo_q       <= 1'b0;
`endif
    end else if (abort) begin
      state_q     <= S_IDLE;
      phase_out_q <= '0;
      cnt_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      seq_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            last_q      <= last_ph;
            loop_q      <= '0;
            busy_q      <= 1'b1;
            cnt_load_q  <= rd_ent.count;
            phase_out_q <= rd_ent.out;
`ifdef PPT_SEQ_TIMEOUT_EN
            tmo_q       <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          state_q   <= S_RUN;
          cnt_run_q <= 1'b1;
`ifdef PPT_SEQ_TIMEOUT_EN
          wd_q      <= '0;
`endif
        end
        S_RUN: begin
          if (cnt_done) begin
            cnt_run_q <= 1'b0;
            if (idx_q != last_q || loop_en) begin
              state_q     <= S_LOAD;
              idx_q       <= nxt_idx_d;
              cnt_load_q  <= rd_ent.count;
              phase_out_q <= rd_ent.out;
              if (idx_q == last_q) begin
                loop_q <= loop_q + 8'd1;
              end
            end else begin
              state_q     <= S_DONE;
              phase_out_q <= '0;
              seq_done_q  <= 1'b1;
            end
          end
`ifdef PPT_SEQ_TIMEOUT_EN
          else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            state_q     <= S_IDLE;
            cnt_run_q   <= 1'b0;
            phase_out_q <= '0;
            busy_q      <= 1'b0;
            tmo_q       <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_run   = cnt_run_q;
  assign phase_out = phase_out_q;
  assign phase_idx = idx_q;
  assign busy      = busy_q;
  assign seq_done  = seq_done_q;
  assign loop_cnt  = loop_q;

endmodule

// File: tb/tb_ppt_phase_sequencer.sv
// tb_ppt_phase_sequencer: randomized bench with a pulse-counter
// stub and a phase-list reference model of the sequence.
module tb_ppt_phase_sequencer;
  import ppt_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [PH_W-1:0]  cfg_addr;
  logic [CNT_W-1:0] cfg_count;
  logic [OUT_W-1:0] cfg_out;
  logic [PH_W-1:0]  last_ph;
  logic             loop_en;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cnt_load;
  logic             cnt_run;
  logic             cnt_done;
  logic [OUT_W-1:0] phase_out;
  logic [PH_W-1:0]  phase_idx;
  logic             busy;
  logic             seq_done;
  logic [7:0]       loop_cnt;
  logic             timeout_err;

  int nvec = 0;
  int nerr = 0;
  int tcnt [NUM_PH];
  int tout [NUM_PH];
  logic pulse = 1'b0;
  bit   pulse_en = 1'b1;
  logic [CNT_W-1:0] sc;
  logic sdone;

  always #5 clk = ~clk;

  ppt_phase_sequencer #(.TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_count(cfg_count), .cfg_out(cfg_out),
    .last_ph(last_ph), .loop_en(loop_en),
    .start(start), .abort(abort),
    .cnt_load(cnt_load), .cnt_run(cnt_run),
    .cnt_done(cnt_done), .phase_out(phase_out),
    .phase_idx(phase_idx), .busy(busy),
    .seq_done(seq_done), .loop_cnt(loop_cnt),
    .timeout_err(timeout_err)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sc <= '0;
      sdone <= 1'b0;
    end else if (!cnt_run) begin
      sc <= cnt_load;
      sdone <= 1'b0;
    end else if (sc == '0) begin
      sdone <= 1'b1;
    end else if (pulse) begin
      sc <= sc - 1'b1;
    end
  end
  assign cnt_done = sdone;

  function automatic logic rnd_pulse();
    return pulse_en && ($urandom_range(0, 3) != 0);
  endfunction

  task automatic wr(input int a, input int c, input int o);
    cfg_we = 1'b1;
    cfg_addr = a[PH_W-1:0];
    cfg_count = c[CNT_W-1:0];
    cfg_out = o[OUT_W-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    tcnt[a] = c;
    tout[a] = o;
  endtask

  task automatic check_idle(input string nm);
    nvec++;
    if (busy !== 1'b0 || cnt_run !== 1'b0 || phase_out !== '0
        || seq_done !== 1'b0) begin
      nerr++;
      $display("FAIL %s busy=%b run=%b out=%h done=%b, required all 0",
               nm, busy, cnt_run, phase_out, seq_done);
    end
  endtask

  task automatic run_seq(input string nm, input int last,
                         input int passes, input bit race,
                         input int newc);
    int q[$];
    int cur;
    int gap = 0;
    int cyc = 0;
    bit prun = 0;
    bit pdone = 0;
    bit raced = 0;
    bit wpend = 0;
    bit fin = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i <= last; i++) q.push_back(i);
    last_ph = last[PH_W-1:0];
    loop_en = (passes > 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      if (wpend) begin
        cfg_we = 1'b0;
        tcnt[1] = newc;
        wpend = 0;
      end
      if (cnt_run && !prun) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL %s extra_phase idx=%0d, required none",
                   nm, phase_idx);
          cur = 0;
        end else begin
          cur = q.pop_front();
          if (int'(phase_idx) != cur || int'(phase_out) != tout[cur]
              || gap != 1) begin
            nerr++;
            $display("FAIL %s phase_start idx=%0d out=%h gap=%0d, required idx=%0d out=%h gap=1",
                     nm, phase_idx, phase_out, gap, cur, tout[cur]);
          end
        end
      end
      if (prun) begin
        nvec++;
        if (cnt_run !== !pdone) begin
          nerr++;
          $display("FAIL %s run_end run=%b, required %b",
                   nm, cnt_run, !pdone);
        end
      end
      if (busy && !cnt_run && !seq_done && q.size() > 0) begin
        nvec++;
        if (int'(cnt_load) != tcnt[q[0]]
            || int'(phase_out) != tout[q[0]]) begin
          nerr++;
          $display("FAIL %s load load=%0d out=%h, required load=%0d out=%h",
                   nm, cnt_load, phase_out, tcnt[q[0]], tout[q[0]]);
        end
        if (race && !raced && q[0] == 1) begin
          raced = 1;
          wpend = 1;
          cfg_we = 1'b1;
          cfg_addr = 1;
          cfg_count = newc[CNT_W-1:0];
          cfg_out = tout[1][OUT_W-1:0];
        end
      end
      if (!seq_done) begin
        nvec++;
        if (busy !== 1'b1) begin
          nerr++;
          $display("FAIL %s busy busy=%b, required 1", nm, busy);
        end
      end else begin
        start = 1'b0;
        nvec++;
        if (q.size() != 0 || int'(loop_cnt) != passes - 1
            || cnt_run !== 1'b0 || phase_out !== '0) begin
          nerr++;
          $display("FAIL %s seq_done left=%0d loops=%0d run=%b out=%h, required 0 %0d 0 0",
                   nm, q.size(), loop_cnt, cnt_run, phase_out, passes - 1);
        end
        @(negedge clk);
        check_idle({nm, "_after"});
        fin = 1;
      end
      if (!fin) begin
        if (int'(loop_cnt) == passes - 1) loop_en = 1'b0;
        gap = cnt_run ? 0 : gap + 1;
        prun = cnt_run;
        pdone = cnt_done;
        start = cnt_run ? 1'($urandom_range(0, 1)) : 1'b0;
        pulse = rnd_pulse();
        cyc++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!fin) begin
      nvec++;
      nerr++;
      $display("FAIL %s no_seq_done after %0d cycles, required completion",
               nm, cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cfg_we = 0; cfg_addr = 0; cfg_count = 0; cfg_out = 0;
    last_ph = 0; loop_en = 0; start = 0; abort = 0;
    for (int i = 0; i < NUM_PH; i++) begin
      tcnt[i] = 0;
      tout[i] = 0;
    end
    repeat (2) @(negedge clk);
    check_idle("reset");
    nvec++;
    if (cnt_load !== '0 || phase_idx !== '0 || loop_cnt !== '0
        || timeout_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_regs load=%h idx=%h loops=%h tmo=%b, required 0",
               cnt_load, phase_idx, loop_cnt, timeout_err);
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_single;
    wr(0, 3, 'hA);
    run_seq("single", 0, 1, 0, 0);
  endtask

  task automatic test_four;
    wr(0, 2, 1); wr(1, 1, 2); wr(2, 0, 4); wr(3, 5, 8);
    run_seq("four", 3, 1, 0, 0);
  endtask

  task automatic test_loop;
    wr(0, 2, 5); wr(1, 1, 6);
    run_seq("loop", 1, 4, 0, 0);
  endtask

  task automatic test_abort;
    int cyc = 0;
    wr(0, 2, 1); wr(1, 3, 2); wr(2, 4, 4); wr(3, 2, 8);
    last_ph = 3;
    loop_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(cnt_run && phase_idx == 2 && loop_cnt == 1) && cyc < 300) begin
      pulse = rnd_pulse();
      cyc++;
      @(negedge clk);
    end
    nvec++;
    if (cyc >= 300) begin
      nerr++;
      $display("FAIL abort_wait cycles=%0d, required phase 2 of pass 2", cyc);
    end
    abort = 1'b1;
    loop_en = 1'b0;
    @(negedge clk);
    check_idle("abort");
    nvec++;
    if (loop_cnt !== 8'd1) begin
      nerr++;
      $display("FAIL abort_loops loops=%0d, required 1", loop_cnt);
    end
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("abort_quiet");
    end
    run_seq("abort_restart", 3, 1, 0, 0);
  endtask

  task automatic test_start_abort_idle;
    start = 1'b1;
    abort = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle("start_abort_idle");
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_race;
    wr(0, 2, 3); wr(1, 4, 9);
    run_seq("race", 1, 2, 1, 1);
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NUM_PH; i++)
        wr(i, $urandom_range(0, 6), $urandom_range(0, 15));
      run_seq("random", $urandom_range(0, 3), $urandom_range(1, 3), 0, 0);
    end
  endtask

  task automatic test_async_rst;
    wr(0, 4, 7); wr(1, 4, 3);
    last_ph = 1;
    loop_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    nvec++;
    if (cnt_load !== '0 || phase_idx !== '0 || loop_cnt !== '0) begin
      nerr++;
      $display("FAIL async_rst_regs load=%h idx=%h loops=%h, required 0",
               cnt_load, phase_idx, loop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    loop_en = 1'b0;
    for (int i = 0; i < NUM_PH; i++) begin
      tcnt[i] = 0;
      tout[i] = 0;
    end
    @(negedge clk);
    run_seq("cleared_table", 1, 1, 0, 0);
  endtask

`ifdef PPT_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    pulse_en = 1'b0;
    pulse = 1'b0;
    wr(0, 5, 3);
    last_ph = 0;
    loop_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    while (cnt_run && n < 100) begin
      n++;
      @(negedge clk);
    end
    nvec++;
    if (n != 20 || busy !== 1'b0 || timeout_err !== 1'b1
        || phase_out !== '0) begin
      nerr++;
      $display("FAIL timeout runs=%0d busy=%b tmo=%b out=%h, required 20 0 1 0",
               n, busy, timeout_err, phase_out);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL timeout_clear tmo=%b busy=%b, required 0 1",
               timeout_err, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pulse_en = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_four();
    test_loop();
    test_abort();
    test_start_abort_idle();
    test_race();
    test_random();
    test_async_rst();
`ifdef PPT_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
